execute_bru_pipe: RTL

Parametrised, pipelined successor of the single-cycle branch execution unit. Resolves conditional branches, jal/jalr and mret, then holds results in a PIPE_DEPTH-stage valid/ready pipeline toward write-back. Adds over the combinational unit: backpressure, mispredict detection (direction and target), a commit-flush that kills in-flight ops, and saturating branch/mispredict counters. Sits between the issue BRU FIFO and the BRU write-back port, and feeds the branch predictor update path.

---
 rtl/bru_pkg.sv | 83 ++++++++
 rtl/bru_pipe_stage.sv | 39 +++
 rtl/execute_bru_pipe.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bru_pkg.sv
// Shared types and resolve logic for the pipelined branch execution unit.
// Payload fields are sized for the widest legal configuration; the top truncates on output.
package bru_pkg;

    localparam int BRU_WMAX   = 64;
    localparam int BRU_TAGMAX = 8;

    typedef enum logic [3:0] {
        BRU_BEQ  = 4'd0,
        BRU_BNE  = 4'd1,
        BRU_BLT  = 4'd2,
        BRU_BGE  = 4'd3,
        BRU_BLTU = 4'd4,
        BRU_BGEU = 4'd5,
        BRU_JAL  = 4'd6,
        BRU_JALR = 4'd7,
        BRU_MRET = 4'd8
    } bru_op_e;

    typedef struct packed {
        logic [BRU_TAGMAX-1:0] rob_id;
        logic [BRU_TAGMAX-1:0] rd_phy;
        logic                  rd_en;
        logic [BRU_TAGMAX-1:0] cp_id;
        logic                  cp_valid;
        logic                  jump;
        logic [BRU_WMAX-1:0]   next_pc;
        logic [BRU_WMAX-1:0]   rd_value;
        logic                  mispredict;
    } bru_result_t;

    // Operands arrive sign-extended to 64 bits, which keeps both the signed and
    // the unsigned orderings of the original XLEN values intact.
    function automatic bru_result_t bru_resolve(
        input logic [3:0]          op,
        input logic [BRU_WMAX-1:0] pc,
        input logic [BRU_WMAX-1:0] imm,
        input logic [BRU_WMAX-1:0] src1,
        input logic [BRU_WMAX-1:0] src2,
        input logic [BRU_WMAX-1:0] mepc,
        input logic                pred_jump,
        input logic [BRU_WMAX-1:0] pred_next_pc,
        input logic [BRU_WMAX-1:0] addr_mask
    );
        bru_result_t         r;
        logic [BRU_WMAX-1:0] seq_pc;
        logic [BRU_WMAX-1:0] target;
        logic                taken;
        r      = '0;
        seq_pc = (pc + 64'd4) & addr_mask;
        target = pc + imm;
        taken  = 1'b0;
        case (op)
            BRU_BEQ:  taken = (src1 == src2);
            BRU_BNE:  taken = (src1 != src2);
            BRU_BLT:  taken = ($signed(src1) < $signed(src2));
            BRU_BGE:  taken = !($signed(src1) < $signed(src2));
            BRU_BLTU: taken = (src1 < src2);
            BRU_BGEU: taken = !(src1 < src2);
            BRU_JAL: begin
                taken      = 1'b1;
                r.rd_value = seq_pc;
            end
            BRU_JALR: begin
                taken      = 1'b1;
                target     = (src1 + imm) & ~64'd1;
                r.rd_value = seq_pc;
            end
            BRU_MRET: begin
                taken  = 1'b1;
                target = mepc;
            end
            default: taken = 1'b0;
        endcase
        target       = target & addr_mask;
        r.jump       = taken;
        r.next_pc    = taken ? target : seq_pc;
        r.mispredict = (taken != pred_jump) ||
                       (taken && (r.next_pc != (pred_next_pc & addr_mask)));
        return r;
    endfunction

endpackage

// File: rtl/bru_pipe_stage.sv
// One valid/ready register stage carrying a resolved branch result.
// A stage accepts whenever it is empty or its contents move on this cycle.
module bru_pipe_stage
    import bru_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        up_valid,
    input  bru_result_t up_data,
    output logic        up_ready,
    output logic        valid,
    output bru_result_t data,
    input  logic        down_ready
);

    logic        valid_r;
    bru_result_t data_r;

    assign up_ready = !valid_r || down_ready;
    assign valid    = valid_r;
    assign data     = data_r;

    // Occupancy flag and payload; payload only loads on a real transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (up_ready) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= up_data;
            end
        end
    end

endmodule

// File: rtl/execute_bru_pipe.sv
// Pipelined branch execution unit: resolves branches/jumps/mret, queues results
// through PIPE_DEPTH stages toward write-back, and tracks branch/mispredict counts.
module execute_bru_pipe
    import bru_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 5,
    parameter int PHY_ID_WIDTH = 6,
    parameter int CP_ID_WIDTH  = 4,
    parameter int PIPE_DEPTH   = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_op,
    input  logic [ADDR_WIDTH-1:0]   in_pc,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [XLEN-1:0]         in_src1,
    input  logic [XLEN-1:0]         in_src2,
    input  logic [ROB_ID_WIDTH-1:0] in_rob_id,
    input  logic [PHY_ID_WIDTH-1:0] in_rd_phy,
    input  logic                    in_rd_en,
    input  logic [CP_ID_WIDTH-1:0]  in_cp_id,
    input  logic                    in_cp_valid,
    input  logic                    in_pred_jump,
    input  logic [ADDR_WIDTH-1:0]   in_pred_next_pc,
    input  logic [XLEN-1:0]         mepc,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ROB_ID_WIDTH-1:0] out_rob_id,
    output logic [PHY_ID_WIDTH-1:0] out_rd_phy,
    output logic                    out_rd_en,
    output logic [CP_ID_WIDTH-1:0]  out_cp_id,
    output logic                    out_cp_valid,
    output logic                    out_jump,
    output logic [ADDR_WIDTH-1:0]   out_next_pc,
    output logic [XLEN-1:0]         out_rd_value,
    output logic                    out_mispredict,
    output logic                    fb_valid,
    output logic [PHY_ID_WIDTH-1:0] fb_phy_id,
    output logic [XLEN-1:0]         fb_value,
    output logic                    bp_upd_valid,
    output logic                    bp_upd_hit,
    output logic [CNT_WIDTH-1:0]    cnt_branch,
    output logic [CNT_WIDTH-1:0]    cnt_mispredict
);

    localparam logic [BRU_WMAX-1:0] ADDR_MASK =
        64'hFFFF_FFFF_FFFF_FFFF >> (BRU_WMAX - ADDR_WIDTH);

    bru_result_t           res_s;
    bru_result_t           stg_data_s [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] stg_valid_s;
    logic [PIPE_DEPTH-1:0] stg_up_ready_s;
    bru_result_t           head_s;
    logic                  hs_s;
    logic                  unused_head_s;
    logic [CNT_WIDTH-1:0]  cnt_branch_r;
    logic [CNT_WIDTH-1:0]  cnt_mispredict_r;

    // Combinational resolve of the offered op plus its tags
    always_comb begin
        res_s = bru_resolve(in_op,
                            64'(in_pc),
                            64'($signed(in_imm)),
                            64'($signed(in_src1)),
                            64'($signed(in_src2)),
                            64'(mepc),
                            in_pred_jump,
                            64'(in_pred_next_pc),
                            ADDR_MASK);
        res_s.rob_id   = 8'(in_rob_id);
        res_s.rd_phy   = 8'(in_rd_phy);
        res_s.rd_en    = in_rd_en;
        res_s.cp_id    = 8'(in_cp_id);
        res_s.cp_valid = in_cp_valid;
    end

    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
        logic        up_valid_s;
        bru_result_t up_data_s;
        logic        down_ready_s;

        if (i == 0) begin : g_first
            assign up_valid_s = in_valid && !flush;
            assign up_data_s  = res_s;
        end else begin : g_chain
            assign up_valid_s = stg_valid_s[i-1];
            assign up_data_s  = stg_data_s[i-1];
        end

        if (i == PIPE_DEPTH - 1) begin : g_head
            assign down_ready_s = out_ready;
        end else begin : g_body
            assign down_ready_s = stg_up_ready_s[i+1];
        end

        bru_pipe_stage u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid   (up_valid_s),
            .up_data    (up_data_s),
            .up_ready   (stg_up_ready_s[i]),
            .valid      (stg_valid_s[i]),
            .data       (stg_data_s[i]),
            .down_ready (down_ready_s)
        );
    end

    assign head_s        = stg_data_s[PIPE_DEPTH-1];
    assign unused_head_s = ^head_s;
    assign in_ready      = !flush && stg_up_ready_s[0];
    // A drain during a flush cycle is not a retirement: no side effects
    assign hs_s          = stg_valid_s[PIPE_DEPTH-1] && out_ready && !flush;

    assign out_valid      = stg_valid_s[PIPE_DEPTH-1];
    assign out_rob_id     = head_s.rob_id[ROB_ID_WIDTH-1:0];
    assign out_rd_phy     = head_s.rd_phy[PHY_ID_WIDTH-1:0];
    assign out_rd_en      = head_s.rd_en;
    assign out_cp_id      = head_s.cp_id[CP_ID_WIDTH-1:0];
    assign out_cp_valid   = head_s.cp_valid;
    assign out_jump       = head_s.jump;
    assign out_next_pc    = head_s.next_pc[ADDR_WIDTH-1:0];
    assign out_rd_value   = head_s.rd_value[XLEN-1:0];
    assign out_mispredict = head_s.mispredict;

    assign fb_valid     = hs_s && head_s.rd_en;
    assign fb_phy_id    = head_s.rd_phy[PHY_ID_WIDTH-1:0];
    assign fb_value     = head_s.rd_value[XLEN-1:0];
    assign bp_upd_valid = hs_s && head_s.cp_valid;
    assign bp_upd_hit   = !head_s.mispredict;

    // Saturating retirement counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_branch_r     <= '0;
            cnt_mispredict_r <= '0;
        end else begin
            if (hs_s && (cnt_branch_r != {CNT_WIDTH{1'b1}})) begin
                cnt_branch_r <= cnt_branch_r + CNT_WIDTH'(1);
            end
            if (hs_s && head_s.mispredict && (cnt_mispredict_r != {CNT_WIDTH{1'b1}})) begin
                cnt_mispredict_r <= cnt_mispredict_r + CNT_WIDTH'(1);
            end
        end
    end

    assign cnt_branch     = cnt_branch_r;
    assign cnt_mispredict = cnt_mispredict_r;

endmodule
